// File: rtl/led_flow_if.sv
// Handshake bundle between the step source and the flowing-LED engine:
// step/mode/pause travel towards the engine, LED drive and cycle pulse come back.
interface led_flow_if #(
  parameter int LED_W = 8
);
  logic             step_in;
  logic [1:0]       mode;
  logic             pause;
  logic [LED_W-1:0] led;
  logic             cycle_done;

  modport master (
    output step_in,
    output mode,
    output pause,
    input  led,
    input  cycle_done
  );

  modport slave (
    input  step_in,
    input  mode,
    input  pause,
    output led,
    output cycle_done
  );
endinterface

// File: rtl/led_flow_ctrl.sv
// Flowing-LED pattern engine: every edge of the slow divider toggle advances
// one of four LED patterns by one position and flags each completed cycle.
module led_flow_ctrl #(
  parameter int LED_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  led_flow_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_ROTL = 2'b00,
    MODE_ROTR = 2'b01,
    MODE_PING = 2'b10,
    MODE_BAR  = 2'b11
  } mode_e;

  localparam logic [LED_W-1:0] LED_LSB  = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB  = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] LED_ONES = {LED_W{1'b1}};
  localparam logic [LED_W-1:0] LED_ZERO = {LED_W{1'b0}};

  logic             step_q;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             done_q, done_d;

  logic             ev;
  mode_e            mode_in;
  logic             eff_dir;
  logic [LED_W-1:0] bounce;

  function automatic logic [LED_W-1:0] start_pattern(input mode_e m);
    return (m == MODE_ROTR) ? LED_MSB : LED_LSB;
  endfunction

  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != LED_ZERO) && ((v & (v - LED_LSB)) == LED_ZERO);
  endfunction

  // A legal bar value is a contiguous run of ones from bit 0 (zero included).
  function automatic logic is_bar(input logic [LED_W-1:0] v);
    return (v & (v + LED_LSB)) == LED_ZERO;
  endfunction

  assign mode_in = mode_e'(bus.mode);
  assign ev      = (bus.step_in != step_q) && !bus.pause;

  // Ping-pong: an endpoint reached with a stale direction reflects instead of
  // shifting off the end, so the one-hot bit can never be lost.
  always_comb begin
    eff_dir = dir_q;
    if (!dir_q && (led_q == LED_MSB)) begin
      eff_dir = 1'b1;
    end else if (dir_q && (led_q == LED_LSB)) begin
      eff_dir = 1'b0;
    end
    bounce = eff_dir ? (led_q >> 1) : (led_q << 1);
  end

  always_comb begin
    led_d  = led_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    done_d = 1'b0;

    if (ev) begin
      if (mode_in != mode_q) begin
        led_d  = start_pattern(mode_in);
        mode_d = mode_in;
        dir_d  = 1'b0;
      end else begin
        unique case (mode_q)
          MODE_ROTL: begin
            if (is_onehot(led_q)) begin
              led_d  = {led_q[LED_W-2:0], led_q[LED_W-1]};
              done_d = (led_q == LED_MSB);
            end else begin
              led_d = start_pattern(MODE_ROTL);
            end
          end

          MODE_ROTR: begin
            if (is_onehot(led_q)) begin
              led_d  = {led_q[0], led_q[LED_W-1:1]};
              done_d = (led_q == LED_LSB);
            end else begin
              led_d = start_pattern(MODE_ROTR);
            end
          end

          MODE_PING: begin
            if (is_onehot(led_q)) begin
              led_d = bounce;
              dir_d = eff_dir;
              if (!eff_dir && (bounce == LED_MSB)) begin
                dir_d = 1'b1;
              end else if (eff_dir && (bounce == LED_LSB)) begin
                dir_d  = 1'b0;
                done_d = 1'b1;
              end
            end else begin
              led_d = start_pattern(MODE_PING);
              dir_d = 1'b0;
            end
          end

          MODE_BAR: begin
            if (!is_bar(led_q)) begin
              led_d = start_pattern(MODE_BAR);
            end else if (led_q == LED_ONES) begin
              led_d  = LED_ZERO;
              done_d = 1'b1;
            end else if (led_q == LED_ZERO) begin
              led_d = LED_LSB;
            end else begin
              led_d = {led_q[LED_W-2:0], 1'b1};
            end
          end

          default: begin
            led_d = start_pattern(MODE_ROTL);
          end
        endcase
      end
    end
  end

  // Stage boundary: step history, pattern state and outputs all register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
      mode_q <= MODE_ROTL;
      dir_q  <= 1'b0;
      led_q  <= LED_LSB;
      done_q <= 1'b0;
    end else begin
      step_q <= bus.step_in;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      done_q <= done_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Randomised bench for led_flow_ctrl against a position-counter model of the
// four LED patterns, preceded by short directed pattern walks.
module tb_led_flow_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  led_flow_if #(.LED_W(W)) intf ();

  led_flow_ctrl #(.LED_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: current mode plus a position counter within that mode's cycle.
  int          m_mode;
  int          m_k;
  logic        step_prev;
  logic [63:0] exp_led;
  logic        exp_done;
  logic [1:0]  cur_mode;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int period(input int m);
    case (m)
      2:       return 2 * W - 2;
      3:       return W + 1;
      default: return W;
    endcase
  endfunction

  function automatic logic [63:0] pattern(input int m, input int kk);
    logic [63:0] one;
    int p;
    one = 64'd1;
    case (m)
      0: return one << kk;
      1: return one << (W - 1 - kk);
      2: begin
        p = (kk < W) ? kk : (2 * W - 2 - kk);
        return one << p;
      end
      default: begin
        p = (kk + 1) % (W + 1);
        return (one << p) - one;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_mode    = 0;
    m_k       = 0;
    step_prev = 1'b0;
    exp_led   = pattern(0, 0);
    exp_done  = 1'b0;
  endtask

  task automatic model_event(input int md);
    exp_done = 1'b0;
    if (md != m_mode) begin
      m_mode = md;
      m_k    = 0;
    end else begin
      m_k = (m_k + 1) % period(m_mode);
      exp_done = (m_mode == 3) ? (m_k == W) : (m_k == 0);
    end
    exp_led = pattern(m_mode, m_k);
  endtask

  // Called at a negedge: drive inputs, predict, check just after the posedge.
  task automatic cyc(input bit tog, input logic [1:0] md, input bit ps);
    bit ev;
    if (tog) intf.step_in = ~intf.step_in;
    intf.mode  = md;
    intf.pause = ps;
    cur_mode   = md;
    if (!rst_n) begin
      model_reset();
    end else begin
      ev = (intf.step_in != step_prev) && !ps;
      step_prev = intf.step_in;
      if (ev) model_event(int'(md));
      else    exp_done = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("led", {56'd0, intf.led}, exp_led);
    chk("cycle_done", {63'd0, intf.cycle_done}, {63'd0, exp_done});
    @(negedge clk);
  endtask

  task automatic toggles(input int n, input logic [1:0] md, input bit ps);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, md, ps);
      cyc(1'b0, md, ps);
    end
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_led", {56'd0, intf.led}, exp_led);
    chk("rst_done", {63'd0, intf.cycle_done}, 64'd0);
    @(negedge clk);
    cyc(1'b0, cur_mode, 1'b0);
    cyc(1'b0, cur_mode, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    intf.step_in = 1'b0;
    intf.mode    = 2'b00;
    intf.pause   = 1'b0;
    cur_mode     = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_led", {56'd0, intf.led}, 64'h01);
    chk("reset_done", {63'd0, intf.cycle_done}, 64'd0);
    rst_n = 1'b1;

    toggles(9, 2'b00, 1'b0);
    toggles(9, 2'b01, 1'b0);
    async_reset();
    toggles(15, 2'b10, 1'b0);
    toggles(12, 2'b11, 1'b0);
    toggles(5, 2'b11, 1'b1);
    toggles(1, 2'b11, 1'b0);

    // Ping-pong to 0x10 on the way down, then reset and restart.
    async_reset();
    toggles(11, 2'b10, 1'b0);
    async_reset();
    toggles(2, 2'b10, 1'b0);

    // Back-to-back transitions, one event each.
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 2'b10, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      logic [1:0] md;
      md = cur_mode;
      if ($urandom_range(0, 39) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end else begin
        cyc(($urandom_range(0, 2) == 0), md, ($urandom_range(0, 7) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
